// File: rtl/asm_datapath_unit.sv
// Operand/shift-count datapath driven by the ASM control unit's Enable strobes.
// Optional operation counter on op_count is built when ASM_DATAPATH_OPCOUNT_EN is defined.
module asm_datapath_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6,
    parameter int LIMIT  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_req,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    input  logic              Enable3,
    input  logic              Enable7,
    input  logic              Enable9,
    input  logic              Enable10,
    output logic [31:0]       output2,
    output logic [31:0]       output5,
    output logic [31:0]       output8,
    output logic [CNT_W-1:0]  result,
    output logic              result_sat,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overrun,
    output logic [15:0]       op_count
);

    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
    localparam logic [DATA_W-1:0] X_ONE   = DATA_W'(1);

    logic              pending;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] x;
    logic [CNT_W-1:0]  c;
    logic              accept;
    logic              x_zero;
    logic              c_at_limit;

    // Enable3 frees the operand register in the same edge, so a coincident request is taken.
    assign accept     = start_req & (~pending | Enable3);
    assign x_zero     = (x == '0);
    assign c_at_limit = (c == LIMIT_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            operand <= '0;
        end else begin
            if (Enable3) begin
                pending <= start_req;
            end else if (accept) begin
                pending <= 1'b1;
            end
            if (accept) begin
                operand <= data_in;
            end
        end
    end

    // X strobes are mutually prioritised; a masked Enable10 leaves C untouched too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            c <= '0;
        end else if (Enable3) begin
            x <= operand;
            c <= '0;
        end else if (Enable7) begin
            x <= x + X_ONE;
        end else if (Enable10) begin
            x <= x >> 1;
            if (!c_at_limit) begin
                c <= c + C_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result       <= '0;
            result_sat   <= 1'b0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (Enable9) begin
                result       <= c;
                result_sat   <= ~x_zero;
                result_valid <= 1'b1;
                if (result_valid && !result_ready) begin
                    overrun <= 1'b1;
                end
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

`ifdef ASM_DATAPATH_OPCOUNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count_q <= 16'd0;
        end else if (Enable9) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = 16'd0;
`endif

    // Status words depend on registers only; the upper bits stay zero for exact "== 1" tests.
    assign busy    = pending;
    assign output2 = {31'b0, pending};
    assign output5 = {31'b0, x[0]};
    assign output8 = {31'b0, x_zero | c_at_limit};

endmodule

// File: tb/tb_asm_datapath_unit.sv
// Directed bench for asm_datapath_unit: a behavioural control loop drives the Enable strobes
// against hand-computed results; a second instance uses LIMIT = 4.
module tb_asm_datapath_unit;

    logic        clk;
    logic        rst;
    logic        start_req;
    logic [31:0] data_in;
    logic        Enable3, Enable7, Enable9, Enable10;
    logic        result_ready;
    logic        sel;

    logic        a_busy, a_sat, a_vld, a_ovr;
    logic [31:0] a_o2, a_o5, a_o8;
    logic [5:0]  a_res;
    logic [15:0] a_opc;

    logic        b_busy, b_sat, b_vld, b_ovr;
    logic [31:0] b_o2, b_o5, b_o8;
    logic [5:0]  b_res;
    logic [15:0] b_opc;

    logic        bsy, sat, vld, ovr;
    logic [31:0] o2, o5, o8;
    logic [5:0]  res;
    logic [15:0] opc;

    int n_checks;
    int n_fail;
    int exp_ops;
    int used_inc;

    logic [31:0] op_tab  [3];
    logic [31:0] res_tab [3];
    logic [31:0] inc_tab [3];

    asm_datapath_unit u_dut_a (
        .clk(clk), .rst(rst), .start_req(start_req), .data_in(data_in), .busy(a_busy),
        .Enable3(Enable3), .Enable7(Enable7), .Enable9(Enable9), .Enable10(Enable10),
        .output2(a_o2), .output5(a_o5), .output8(a_o8),
        .result(a_res), .result_sat(a_sat), .result_valid(a_vld), .result_ready(result_ready),
        .overrun(a_ovr), .op_count(a_opc)
    );

    asm_datapath_unit #(.LIMIT(4)) u_dut_b (
        .clk(clk), .rst(rst), .start_req(start_req), .data_in(data_in), .busy(b_busy),
        .Enable3(Enable3), .Enable7(Enable7), .Enable9(Enable9), .Enable10(Enable10),
        .output2(b_o2), .output5(b_o5), .output8(b_o8),
        .result(b_res), .result_sat(b_sat), .result_valid(b_vld), .result_ready(result_ready),
        .overrun(b_ovr), .op_count(b_opc)
    );

    assign bsy = sel ? b_busy : a_busy;
    assign sat = sel ? b_sat  : a_sat;
    assign vld = sel ? b_vld  : a_vld;
    assign ovr = sel ? b_ovr  : a_ovr;
    assign o2  = sel ? b_o2   : a_o2;
    assign o5  = sel ? b_o5   : a_o5;
    assign o8  = sel ? b_o8   : a_o8;
    assign res = sel ? b_res  : a_res;
    assign opc = sel ? b_opc  : a_opc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected end before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_opc();
`ifdef ASM_DATAPATH_OPCOUNT_EN
        return 32'(exp_ops);
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_ops = 0;
        @(negedge clk);
    endtask

    // Request an operand, wait for output2, then load X with Enable3.
    task automatic start_op(input logic [31:0] d);
        int guard;
        start_req = 1'b1;
        data_in   = d;
        @(negedge clk);
        start_req = 1'b0;
        guard = 0;
        while (o2 != 32'd1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("pending_set", o2, 32'd1);
        Enable3 = 1'b1;
        @(negedge clk);
        Enable3 = 1'b0;
        check("busy_clear", {31'b0, bsy}, 32'd0);
    endtask

    // Control-unit behaviour after Enable3: round up to odd, shift until done, publish.
    task automatic finish_op();
        int guard;
        used_inc = 0;
        if (o5 != 32'd1) begin
            Enable7 = 1'b1;
            used_inc = 1;
            @(negedge clk);
            Enable7 = 1'b0;
        end
        guard = 0;
        while (o8 != 32'd1 && guard < 100) begin
            Enable10 = 1'b1;
            @(negedge clk);
            Enable10 = 1'b0;
            guard++;
        end
        check("shift_done", o8, 32'd1);
        Enable9 = 1'b1;
        @(negedge clk);
        Enable9 = 1'b0;
        exp_ops++;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_ops = 0; used_inc = 0;
        rst = 1'b0; sel = 1'b0; start_req = 1'b0; data_in = '0;
        Enable3 = 1'b0; Enable7 = 1'b0; Enable9 = 1'b0; Enable10 = 1'b0;
        result_ready = 1'b0;
        op_tab[0] = 32'd8; op_tab[1] = 32'd0; op_tab[2] = 32'hFFFF_FFFF;
        res_tab[0] = 32'd4; res_tab[1] = 32'd1; res_tab[2] = 32'd32;
        inc_tab[0] = 32'd1; inc_tab[1] = 32'd1; inc_tab[2] = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bsy}, 32'd0);
        check("rst_out2", o2, 32'd0);
        check("rst_out5", o5, 32'd0);
        check("rst_out8", o8, 32'd1);
        check("rst_valid", {31'b0, vld}, 32'd0);
        check("rst_overrun", {31'b0, ovr}, 32'd0);
        check("rst_opcount", {16'b0, opc}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 6 -> 7 -> 3 -> 1 -> 0
        start_op(32'd6);
        finish_op();
        check("op6_result", {26'b0, res}, 32'd3);
        check("op6_sat", {31'b0, sat}, 32'd0);
        check("op6_valid", {31'b0, vld}, 32'd1);
        check("op6_overrun", {31'b0, ovr}, 32'd0);
        @(negedge clk);
        check("op6_valid_hold", {31'b0, vld}, 32'd1);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("op6_valid_clear", {31'b0, vld}, 32'd0);
        check("op6_result_hold", {26'b0, res}, 32'd3);

        for (int i = 0; i < 3; i++) begin
            start_op(op_tab[i]);
            finish_op();
            check("tab_result", {26'b0, res}, res_tab[i]);
            check("tab_sat", {31'b0, sat}, 32'd0);
            check("tab_inc_used", 32'(used_inc), inc_tab[i]);
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
        end

        // Two results without a consumer
        start_op(32'd6);
        finish_op();
        check("ovr_first", {31'b0, ovr}, 32'd0);
        start_op(32'd8);
        finish_op();
        check("ovr_set", {31'b0, ovr}, 32'd1);
        check("ovr_result", {26'b0, res}, 32'd4);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("ovr_sticky", {31'b0, ovr}, 32'd1);
        check("ovr_valid_clear", {31'b0, vld}, 32'd0);

        // LIMIT = 4 instance: 0xFF stops after four shifts with X != 0
        do_reset();
        sel = 1'b1;
        start_op(32'h0000_00FF);
        finish_op();
        check("lim_result", {26'b0, res}, 32'd4);
        check("lim_sat", {31'b0, sat}, 32'd1);
        check("lim_out8", o8, 32'd1);
        sel = 1'b0;
        do_reset();

        // Enable7 wins over Enable10: 4 -> 5, C stays 0
        start_op(32'd4);
        Enable7 = 1'b1;
        Enable10 = 1'b1;
        @(negedge clk);
        Enable7 = 1'b0;
        Enable10 = 1'b0;
        check("prio_out5", o5, 32'd1);
        Enable9 = 1'b1;
        @(negedge clk);
        Enable9 = 1'b0;
        exp_ops++;
        check("prio_result", {26'b0, res}, 32'd0);
        check("prio_sat", {31'b0, sat}, 32'd1);

        // Request in the same cycle as Enable3, then a request while busy
        start_req = 1'b1;
        data_in = 32'd5;
        @(negedge clk);
        start_req = 1'b0;
        check("sc_busy0", {31'b0, bsy}, 32'd1);
        Enable3 = 1'b1;
        start_req = 1'b1;
        data_in = 32'd10;
        @(negedge clk);
        Enable3 = 1'b0;
        start_req = 1'b0;
        check("sc_busy1", {31'b0, bsy}, 32'd1);
        check("sc_old_x", o5, 32'd1);
        start_req = 1'b1;
        data_in = 32'd99;
        @(negedge clk);
        start_req = 1'b0;
        check("sc_ignored_busy", {31'b0, bsy}, 32'd1);
        Enable3 = 1'b1;
        @(negedge clk);
        Enable3 = 1'b0;
        check("sc_busy2", {31'b0, bsy}, 32'd0);
        check("sc_new_x", o5, 32'd0);
        finish_op();
        check("sc_result", {26'b0, res}, 32'd4);
        check("sc_valid", {31'b0, vld}, 32'd1);

        // Asynchronous reset between edges in the middle of shifting
        start_op(32'hFFFF_FFFF);
        Enable10 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", {31'b0, bsy}, 32'd0);
        check("arst_out2", o2, 32'd0);
        check("arst_out5", o5, 32'd0);
        check("arst_out8", o8, 32'd1);
        check("arst_valid", {31'b0, vld}, 32'd0);
        check("arst_result", {26'b0, res}, 32'd0);
        check("arst_sat", {31'b0, sat}, 32'd0);
        check("arst_overrun", {31'b0, ovr}, 32'd0);
        check("arst_opcount", {16'b0, opc}, 32'd0);
        Enable10 = 1'b0;
        exp_ops = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        result_ready = 1'b1;
        start_op(32'd6);
        finish_op();
        start_op(32'd8);
        finish_op();
        start_op(32'd0);
        finish_op();
        @(negedge clk);
        result_ready = 1'b0;
        check("opcount_three", {16'b0, opc}, exp_opc());
        check("final_result", {26'b0, res}, 32'd1);
        check("final_overrun", {31'b0, ovr}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/asm_datapath_unit.md
Name: asm_datapath_unit

Overview:
- Datapath stage directly downstream of the generated ASM control unit.
- Consumes the control unit's Enable3/Enable7/Enable9/Enable10 strobes.
- Produces the 32-bit status words output2/output5/output8 that the control unit tests with "== 1".
- Accepts an operand through a start handshake, conditionally rounds it up to odd, then shifts it right until zero, counting shifts. Presents the count to a downstream consumer through a valid/ready result handshake.

Parameters:
- DATA_W, 32, operand/X register width.
- CNT_W, 6, shift-counter and result width; must hold LIMIT.
- LIMIT, 32, maximum shift count before forced stop.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- start_req  in  1  operand request strobe.
- data_in  in  DATA_W  operand, sampled when a request is accepted.
- busy  out  1  request pending (operand held, not yet consumed).
- Enable3  in  1  load X from operand register, clear C.
- Enable7  in  1  X <= X + 1.
- Enable9  in  1  publish result.
- Enable10  in  1  X <= X >> 1, C <= C + 1.
- output2  out  32  {31'b0, pending}.
- output5  out  32  {31'b0, X[0]}.
- output8  out  32  {31'b0, (X == 0) || (C == LIMIT)}.
- result  out  CNT_W  published shift count.
- result_sat  out  1  published result stopped by LIMIT with X != 0.
- result_valid  out  1  result available.
- result_ready  in  1  downstream accepts result.
- overrun  out  1  sticky: result overwritten while still valid.
- op_count  out  16  completed operations (see Optional Feature).

Behaviour:
- Reset (rst = 0, asynchronous): pending, X, C, operand, result, result_sat, result_valid, overrun, op_count all 0. busy = 0, output2 = 0, output5 = 0, output8 = 1 (X == 0).
- output2/5/8 are combinational from registers only. Upper 31 bits are always 0, so "== 1" compares are exact. No combinational path from any Enable* input to output*.
- Start handshake:
  - start_req with pending = 0: operand <= data_in, pending <= 1.
  - start_req with pending = 1 and no Enable3 in the same cycle: ignored, operand unchanged.
- Enable3:
  - X <= operand, C <= 0, pending <= 0.
  - Same cycle as start_req: X takes the old operand, the new request is accepted (operand <= data_in, pending stays 1). Set wins.
- X write priority if several strobes are high: Enable3 > Enable7 > Enable10. Lower-priority strobes are ignored for X; Enable10 also skips its C increment when masked.
- Enable7: X wraps modulo 2^DATA_W.
- Enable10: logical shift right, zero fill. C saturates at LIMIT and never wraps.
- Enable9:
  - result <= C, result_sat <= (X != 0), result_valid <= 1.
  - If result_valid = 1 and result_ready = 0 in the same cycle: overrun <= 1. overrun clears only on reset.
  - Enable9 in the same cycle as a handshake (valid & ready): the new result is published and valid stays 1.
- Result handshake: valid & ready with no Enable9 clears result_valid next edge. result holds its value until the next Enable9.
- Enable9 is independent of the X strobes and is processed in the same cycle as any of them. It uses pre-edge X and C.
- Reset mid-operation: immediate return to reset values; any in-flight result is lost.
- Closed-loop latency with the control unit, from Enable3 to result_valid: 1 + [1 if X even] + shifts + 1 cycles. The control unit uses rst as its own reset.

Optional Feature:
- Macro: ASM_DATAPATH_OPCOUNT_EN.
- Defined: op_count is a 16-bit register, reset 0, incremented on each Enable9, wrapping 0xFFFF -> 0.
- Undefined: op_count is constant 0 and no counter register is synthesized.

Test Plan:
- Reset then start_req with data_in = 6, closed loop with control unit -> X path 6 -> 7 -> 3 -> 1 -> 0. result = 3, result_sat = 0, result_valid = 1 until result_ready; output2 returns to 0 after Enable3.
- Operands 8 / 0 / 0xFFFFFFFF -> results 4 / 1 / 32. With 0xFFFFFFFF, output5 = 1 so Enable7 is never asserted. result_sat = 0 in all three cases.
- Instance with LIMIT = 4, operand 0xFF -> C saturates at 4, output8 = 1, result = 4, result_sat = 1.
- Hold result_ready = 0 across two completed operations -> overrun = 1 after the second Enable9, result shows the second count.
- start_req asserted the same cycle as Enable3 (open loop) -> X = old operand, operand = new data_in, busy stays 1. A second start_req while busy is ignored.
- Assert rst low mid-shift (asynchronous, between edges) -> all outputs at reset values immediately. With the macro defined, op_count = 0 after reset and reaches 3 after three operations.
